// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and byte geometry for the FIFO-fed UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} uart_tx_state_t;

   localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter with a one-cycle tick on the last clock of each bit.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] r_count;

   assign o_tick = (r_count == LAST);

   // Reload on the tick itself so every bit is exactly CLKS_PER_BIT clocks.
   always_ff @(posedge clk) begin
      r_count <= (rst || i_clear || o_tick) ? '0 : r_count + W'(1);
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO words and sends each as back-to-back 8N1 frames,
// least-significant byte first.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_read_en,
   output logic                  tx,
   output logic                  busy
);

   localparam int BYTES = DATA_WIDTH / BITS_PER_BYTE;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(BITS_PER_BYTE - 1);

   if (DATA_WIDTH % BITS_PER_BYTE != 0 || CLKS_PER_BIT < 2) begin : g_param_check
      $error("fifo_uart_tx: DATA_WIDTH must be a multiple of 8 and CLKS_PER_BIT >= 2");
   end

   uart_tx_state_t        r_state;
   uart_tx_state_t        w_next;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [BW-1:0]         r_byte;
   logic [2:0]            r_bit;
   logic                  r_tx;
   logic                  r_busy;
   logic                  w_tick;
   logic                  w_clear;

   assign fifo_read_en = !rst && (r_state == IDLE) && enable && !fifo_empty;
   assign w_clear      = (r_state == IDLE) || (r_state == WAIT);
   assign tx           = r_tx;
   assign busy         = r_busy;

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk    (clk),
      .rst    (rst),
      .i_clear(w_clear),
      .o_tick (w_tick)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = fifo_read_en ? WAIT : IDLE;
         WAIT:    w_next = START;
         START:   w_next = w_tick ? DATA : START;
         DATA:    w_next = (w_tick && r_bit == LAST_BIT) ? STOP : DATA;
         STOP:    w_next = w_tick ? ((r_byte == LAST_BYTE) ? IDLE : START) : STOP;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != IDLE);
         // Read data is valid in WAIT, one cycle after the pop.
         if (r_state == WAIT) begin
            r_shift <= fifo_data;
            r_byte  <= '0;
            r_tx    <= 1'b0;
         end else if (w_tick) begin
            unique case (r_state)
               START: begin
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_bit   <= '0;
               end
               DATA: begin
                  if (r_bit == LAST_BIT) begin
                     r_tx <= 1'b1;
                  end else begin
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                     r_bit   <= r_bit + 3'd1;
                  end
               end
               STOP: begin
                  if (w_next == START) begin
                     r_byte <= r_byte + BW'(1);
                     r_tx   <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed scenarios with random payloads, a cycle-level frame model
// and an independent UART byte decoder.
module tb_fifo_uart_tx;

   localparam int CPB   = 4;
   localparam int DW    = 16;
   localparam int WORDC = 2 * 10 * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_read_en;
   logic          tx;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [DW-1:0] mem [0:63];
   int n_push = 0;
   int n_pop  = 0;

   int m_pop  = -1000;
   int m_end  = 0;
   int m_idx  = 0;
   logic [DW-1:0] m_word = '0;

   int pops[$];
   logic [7:0] rxq[$];
   int rx_cnt = 0;
   logic [7:0] rx_sh = '0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_read_en(fifo_read_en),
      .tx          (tx),
      .busy        (busy)
   );

   assign fifo_empty = (n_push == n_pop);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_read_en) begin
         fifo_data <= mem[n_pop];
         n_pop     <= n_pop + 1;
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Line level at offset k from the first start bit of a word: start, 8 data, stop per byte.
   function automatic logic exp_bit(logic [DW-1:0] w, int k);
      int b = (k % (10 * CPB)) / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return w[(k / (10 * CPB)) * 8 + b - 1];
   endfunction

   always @(negedge clk) begin
      logic e_tx, e_busy, e_re;
      e_busy = (cyc >= m_pop + 1) && (cyc < m_end);
      e_tx   = (cyc >= m_pop + 2 && cyc < m_end) ? exp_bit(m_word, cyc - m_pop - 2) : 1'b1;
      e_re   = !rst && (cyc >= m_end) && enable && (n_push > m_idx);
      chk("tx", tx, e_tx);
      chk("busy", busy, e_busy);
      chk("read_en", fifo_read_en, e_re);
      if (fifo_read_en) pops.push_back(cyc);
      if (rst) begin
         m_end = cyc + 1;
      end else if (e_re) begin
         m_pop  = cyc;
         m_end  = cyc + WORDC + 2;
         m_word = mem[m_idx];
         m_idx++;
      end
   end

   // Decoder: start edge at count 0, data bit b sampled mid-bit at 4b+2, stop at 38.
   always @(negedge clk) begin
      if (rst) begin
         rx_cnt = 0;
      end else if (rx_cnt == 0) begin
         if (tx === 1'b0) rx_cnt = 1;
      end else begin
         if (rx_cnt % CPB == 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh[rx_cnt / CPB - 1] = tx;
         if (rx_cnt == 9 * CPB + 2) begin
            chk("stop_bit", tx, 1'b1);
            rxq.push_back(rx_sh);
         end
         rx_cnt = (rx_cnt == 10 * CPB - 1) ? 0 : rx_cnt + 1;
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(logic [DW-1:0] w);
      mem[n_push] = w;
      n_push++;
   endtask

   task automatic chk_word(string tag, int idx, logic [DW-1:0] w);
      chk({tag, "_lo"}, rxq.size() > idx ? rxq[idx] : 8'hxx, w[7:0]);
      chk({tag, "_hi"}, rxq.size() > idx + 1 ? rxq[idx + 1] : 8'hxx, w[15:8]);
   endtask

   initial begin
      int p0, n0;
      logic [DW-1:0] wa, wb;
      rst = 1'b1;
      enable = 1'b0;
      tick(3);
      chk("reset_pops", pops.size(), 0);
      rst = 1'b0;
      enable = 1'b1;
      tick(20);
      chk("empty_no_pop", pops.size(), 0);
      chk("empty_no_bytes", rxq.size(), 0);

      p0 = pops.size(); n0 = rxq.size();
      push(16'hA55A);
      tick(WORDC + 10);
      chk("single_pops", pops.size(), p0 + 1);
      chk("single_bytes", rxq.size(), n0 + 2);
      chk_word("a55a", n0, 16'hA55A);
      chk("single_idle", busy, 1'b0);

      p0 = pops.size(); n0 = rxq.size();
      push(16'h1234);
      push(16'hFFFF);
      tick(2 * WORDC + 15);
      chk("b2b_pops", pops.size(), p0 + 2);
      chk("b2b_spacing", pops.size() >= p0 + 2 ? pops[p0 + 1] - pops[p0] : -1, WORDC + 2);
      chk_word("w1234", n0, 16'h1234);
      chk_word("wffff", n0 + 2, 16'hFFFF);

      p0 = pops.size(); n0 = rxq.size();
      wb = 16'($urandom);
      push(16'h00FF);
      push(wb);
      tick(10);
      enable = 1'b0;
      tick(WORDC + 20);
      chk("en_drop_pops", pops.size(), p0 + 1);
      chk("en_drop_bytes", rxq.size(), n0 + 2);
      chk_word("w00ff", n0, 16'h00FF);
      enable = 1'b1;
      tick(WORDC + 10);
      chk("en_resume_pops", pops.size(), p0 + 2);
      chk_word("w_rand_b", n0 + 2, wb);

      p0 = pops.size(); n0 = rxq.size();
      push(16'($urandom) | 16'h0001);
      tick(10);
      rst = 1'b1;
      tick(1);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      tick(1);
      rst = 1'b0;
      tick(60);
      chk("rst_pops", pops.size(), p0 + 1);
      chk("rst_no_partial", rxq.size(), n0);

      p0 = pops.size(); n0 = rxq.size();
      wa = 16'($urandom);
      wb = 16'($urandom);
      push(wa);
      tick(WORDC + 1);
      push(wb);
      tick(WORDC + 10);
      chk("refill_pops", pops.size(), p0 + 2);
      chk("refill_spacing", pops.size() >= p0 + 2 ? pops[p0 + 1] - pops[p0] : -1, WORDC + 2);
      chk_word("w_rand_a", n0, wa);
      chk_word("w_rand_b2", n0 + 2, wb);
      chk("refill_bytes", rxq.size(), n0 + 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
